// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB boundary register: word-organised data memory with byte/half/word
// stores and sign/zero-extending loads, write-back value select and the WB-facing register.
module mem_wb_stage #(
   parameter int unsigned DEPTH_LOG2   = 10,
   parameter int unsigned JAL_LINK_OFS = 4
) (
   input  logic        clk,
   input  logic        CLR,
   input  logic        EN,
   input  logic        bb,
   input  logic        In,
   input  logic [31:0] IR_in,
   input  logic [31:0] PC_in,
   input  logic [31:0] R1_in,
   input  logic [31:0] R2_in,
   input  logic [31:0] RD1_in,
   input  logic [4:0]  WbRegNum_in,
   input  logic        RegWrite_in,
   input  logic        LOWrite_in,
   input  logic        HIWrite_in,
   input  logic        MemtoReg_in,
   input  logic        JAL_in,
   input  logic        SYSCALL_in,
   input  logic        MemWrite_in,
   input  logic        UnsignedExt_Mem_in,
   input  logic        Byte_in,
   input  logic        Half_in,
   output logic        Out,
   output logic [31:0] IR,
   output logic [31:0] PC,
   output logic [31:0] WbData,
   output logic [31:0] RD1,
   output logic [4:0]  WbRegNum,
   output logic        RegWrite,
   output logic        LOWrite,
   output logic        HIWrite,
   output logic        SYSCALL
);

   localparam int unsigned WORDS = 2 ** DEPTH_LOG2;

   logic [31:0]           mem [WORDS];
   logic [DEPTH_LOG2-1:0] word_idx;
   logic [1:0]            lane;
   logic                  mem_we;
   logic [3:0]            byte_en;
   logic [31:0]           wr_data;
   logic [31:0]           rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           load_data;
   logic [31:0]           wb_sel;

   // Upper address bits are dropped, so accesses wrap modulo the memory size.
   assign word_idx = R1_in[DEPTH_LOG2+1:2];
   assign lane     = R1_in[1:0];

   // Stalled, bubbled or flushed instructions must never reach memory.
   assign mem_we = In & MemWrite_in & EN & ~CLR;

   always_comb begin
      byte_en = 4'b1111;
      wr_data = R2_in;
      if (Byte_in) begin
         byte_en = 4'b0001 << lane;
         wr_data = {4{R2_in[7:0]}};
      end else if (Half_in) begin
         byte_en = lane[1] ? 4'b1100 : 4'b0011;
         wr_data = {2{R2_in[15:0]}};
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int l = 0; l < 4; l++) begin
            if (byte_en[l]) begin
               mem[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
            end
         end
      end
   end

   assign rd_word = mem[word_idx];

   always_comb begin
      rd_byte = rd_word[{lane, 3'b000} +: 8];
      rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      if (Byte_in) begin
         load_data = UnsignedExt_Mem_in ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end else if (Half_in) begin
         load_data = UnsignedExt_Mem_in ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end else begin
         load_data = rd_word;
      end
   end

   always_comb begin
      if (JAL_in) begin
         wb_sel = PC_in + JAL_LINK_OFS;
      end else if (MemtoReg_in) begin
         wb_sel = load_data;
      end else begin
         wb_sel = R1_in;
      end
   end

   // A bubble kills the instruction but leaves IR/PC/RD1 visible for debug and HI/LO paths.
   always_ff @(posedge clk) begin
      if (CLR) begin
         Out      <= 1'b0;
         IR       <= '0;
         PC       <= '0;
         WbData   <= '0;
         RD1      <= '0;
         WbRegNum <= '0;
         RegWrite <= 1'b0;
         LOWrite  <= 1'b0;
         HIWrite  <= 1'b0;
         SYSCALL  <= 1'b0;
      end else if (EN) begin
         Out      <= In;
         IR       <= IR_in;
         PC       <= PC_in;
         WbData   <= wb_sel;
         RD1      <= RD1_in;
         WbRegNum <= WbRegNum_in;
         RegWrite <= RegWrite_in;
         LOWrite  <= LOWrite_in;
         HIWrite  <= HIWrite_in;
         SYSCALL  <= SYSCALL_in;
      end else if (bb) begin
         Out      <= 1'b0;
         WbData   <= '0;
         WbRegNum <= '0;
         RegWrite <= 1'b0;
         LOWrite  <= 1'b0;
         HIWrite  <= 1'b0;
         SYSCALL  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a byte-addressed reference model.
module tb_mem_wb_stage;

   localparam int unsigned DEPTH_LOG2 = 10;
   localparam int unsigned NBYTES     = 4 * (2 ** DEPTH_LOG2);

   logic        clk = 1'b0;
   logic        CLR, EN, bb, In;
   logic [31:0] IR_in, PC_in, R1_in, R2_in, RD1_in;
   logic [4:0]  WbRegNum_in;
   logic        RegWrite_in, LOWrite_in, HIWrite_in, MemtoReg_in, JAL_in, SYSCALL_in;
   logic        MemWrite_in, UnsignedExt_Mem_in, Byte_in, Half_in;
   logic        Out;
   logic [31:0] IR, PC, WbData, RD1;
   logic [4:0]  WbRegNum;
   logic        RegWrite, LOWrite, HIWrite, SYSCALL;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mbytes [NBYTES];
   logic        e_out, e_rw, e_lo, e_hi, e_sys;
   logic [31:0] e_ir, e_pc, e_wb, e_rd1;
   logic [4:0]  e_rn;

   mem_wb_stage #(.DEPTH_LOG2(DEPTH_LOG2), .JAL_LINK_OFS(4)) dut (
      .clk(clk), .CLR(CLR), .EN(EN), .bb(bb), .In(In),
      .IR_in(IR_in), .PC_in(PC_in), .R1_in(R1_in), .R2_in(R2_in), .RD1_in(RD1_in),
      .WbRegNum_in(WbRegNum_in), .RegWrite_in(RegWrite_in), .LOWrite_in(LOWrite_in),
      .HIWrite_in(HIWrite_in), .MemtoReg_in(MemtoReg_in), .JAL_in(JAL_in),
      .SYSCALL_in(SYSCALL_in), .MemWrite_in(MemWrite_in),
      .UnsignedExt_Mem_in(UnsignedExt_Mem_in), .Byte_in(Byte_in), .Half_in(Half_in),
      .Out(Out), .IR(IR), .PC(PC), .WbData(WbData), .RD1(RD1), .WbRegNum(WbRegNum),
      .RegWrite(RegWrite), .LOWrite(LOWrite), .HIWrite(HIWrite), .SYSCALL(SYSCALL)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] addr, input logic b,
                                              input logic h, input logic u);
      int unsigned a;
      int          v;
      a = addr % NBYTES;
      if (b) begin
         v = int'(mbytes[a]);
         if (!u && v >= 128) v -= 256;
         return 32'(v);
      end else if (h) begin
         a = a - a % 2;
         v = int'(mbytes[a]) + 256 * int'(mbytes[a+1]);
         if (!u && v >= 32768) v -= 65536;
         return 32'(v);
      end
      a = a - a % 4;
      return {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]};
   endfunction

   task automatic model_store(input logic [31:0] addr, input logic [31:0] data,
                              input logic b, input logic h);
      int unsigned a;
      a = addr % NBYTES;
      if (b) begin
         mbytes[a] = data[7:0];
      end else if (h) begin
         a = a - a % 2;
         mbytes[a]   = data[7:0];
         mbytes[a+1] = data[15:8];
      end else begin
         a = a - a % 4;
         for (int k = 0; k < 4; k++) mbytes[a+k] = 8'(data >> (8 * k));
      end
   endtask

   // Predict the register contents for the coming edge, clock it, then compare everything.
   task automatic cycle();
      logic [31:0] ld, wb;
      logic        do_store;
      ld = model_load(R1_in, Byte_in, Half_in, UnsignedExt_Mem_in);
      if (JAL_in) wb = PC_in + 32'd4;
      else if (MemtoReg_in) wb = ld;
      else wb = R1_in;
      do_store = !CLR && EN && In && MemWrite_in;
      if (CLR) begin
         e_out = 0; e_ir = 0; e_pc = 0; e_wb = 0; e_rd1 = 0; e_rn = 0;
         e_rw = 0; e_lo = 0; e_hi = 0; e_sys = 0;
      end else if (EN) begin
         e_out = In; e_ir = IR_in; e_pc = PC_in; e_wb = wb; e_rd1 = RD1_in;
         e_rn = WbRegNum_in; e_rw = RegWrite_in; e_lo = LOWrite_in; e_hi = HIWrite_in;
         e_sys = SYSCALL_in;
      end else if (bb) begin
         e_out = 0; e_wb = 0; e_rn = 0; e_rw = 0; e_lo = 0; e_hi = 0; e_sys = 0;
      end
      @(posedge clk);
      #1;
      if (do_store) model_store(R1_in, R2_in, Byte_in, Half_in);
      check("out", 32'(Out), 32'(e_out));
      check("ir", IR, e_ir);
      check("pc", PC, e_pc);
      check("wbdata", WbData, e_wb);
      check("rd1", RD1, e_rd1);
      check("regnum", 32'(WbRegNum), 32'(e_rn));
      check("regwrite", 32'(RegWrite), 32'(e_rw));
      check("lowrite", 32'(LOWrite), 32'(e_lo));
      check("hiwrite", 32'(HIWrite), 32'(e_hi));
      check("syscall", 32'(SYSCALL), 32'(e_sys));
   endtask

   task automatic idle();
      CLR = 0; EN = 0; bb = 0; In = 0;
      IR_in = 0; PC_in = 0; R1_in = 0; R2_in = 0; RD1_in = 0; WbRegNum_in = 0;
      RegWrite_in = 0; LOWrite_in = 0; HIWrite_in = 0; MemtoReg_in = 0; JAL_in = 0;
      SYSCALL_in = 0; MemWrite_in = 0; UnsignedExt_Mem_in = 0; Byte_in = 0; Half_in = 0;
   endtask

   task automatic mem_op(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                         input logic b, input logic h, input logic u);
      idle();
      EN = 1; In = 1;
      IR_in = $urandom; PC_in = $urandom; RD1_in = $urandom;
      R1_in = addr; R2_in = data;
      MemWrite_in = wr; MemtoReg_in = !wr; RegWrite_in = !wr;
      WbRegNum_in = 5'($urandom);
      Byte_in = b; Half_in = h; UnsignedExt_Mem_in = u;
      cycle();
   endtask

   task automatic rand_inputs();
      CLR = ($urandom_range(0, 15) == 0);
      EN  = ($urandom_range(0, 3) != 0);
      bb  = 1'($urandom);
      In  = ($urandom_range(0, 7) != 0);
      IR_in = $urandom; PC_in = $urandom; R2_in = $urandom; RD1_in = $urandom;
      R1_in = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      WbRegNum_in = 5'($urandom);
      RegWrite_in = 1'($urandom); LOWrite_in = 1'($urandom); HIWrite_in = 1'($urandom);
      SYSCALL_in = ($urandom_range(0, 7) == 0);
      MemWrite_in = ($urandom_range(0, 2) == 0);
      MemtoReg_in = !MemWrite_in && 1'($urandom);
      JAL_in = ($urandom_range(0, 7) == 0);
      UnsignedExt_Mem_in = 1'($urandom);
      Byte_in = 1'($urandom);
      Half_in = MemWrite_in ? (!Byte_in && 1'($urandom)) : 1'($urandom);
   endtask

   initial begin
      for (int i = 0; i < int'(NBYTES); i++) mbytes[i] = 8'h00;

      // Flush with junk inputs, then a simple ALU-result pass-through.
      rand_inputs();
      CLR = 1;
      cycle();
      check("rst_out", 32'(Out), 32'h0);
      check("rst_wbdata", WbData, 32'h0);
      idle();
      EN = 1; In = 1; R1_in = 32'h1234; RegWrite_in = 1; WbRegNum_in = 5'd5;
      cycle();
      check("first_wbdata", WbData, 32'h1234);
      check("first_regnum", 32'(WbRegNum), 32'd5);

      // Word store / load and address wrap.
      mem_op(32'h10, 32'hDEADBEEF, 1, 0, 0, 0);
      mem_op(32'h10, 32'h0, 0, 0, 0, 0);
      check("lw", WbData, 32'hDEADBEEF);
      mem_op(32'h10 + 32'(NBYTES), 32'h0, 0, 0, 0, 0);
      check("lw_wrap", WbData, 32'hDEADBEEF);

      // Sub-word lanes and extension.
      mem_op(32'h20, 32'h0, 1, 0, 0, 0);
      mem_op(32'h23, 32'h1FF, 1, 1, 0, 0);
      mem_op(32'h20, 32'h0, 0, 0, 0, 0);
      check("sb_word", WbData, 32'hFF000000);
      mem_op(32'h23, 32'h0, 0, 1, 0, 0);
      check("lb", WbData, 32'hFFFFFFFF);
      mem_op(32'h23, 32'h0, 0, 1, 0, 1);
      check("lbu", WbData, 32'h000000FF);
      mem_op(32'h22, 32'h8001, 1, 0, 1, 0);
      mem_op(32'h20, 32'h0, 0, 0, 0, 0);
      check("sh_word", WbData, 32'h80010000);
      mem_op(32'h22, 32'h0, 0, 0, 1, 0);
      check("lh", WbData, 32'hFFFF8001);
      mem_op(32'h23, 32'h0, 0, 0, 1, 1);
      check("lhu", WbData, 32'h00008001);

      // Stall with a pending store: no write, outputs hold.
      idle();
      In = 1; MemWrite_in = 1; R1_in = 32'h20; R2_in = 32'h12345678;
      cycle();
      check("stall_wbdata", WbData, 32'h00008001);
      mem_op(32'h20, 32'h0, 0, 0, 0, 0);
      check("stall_nowrite", WbData, 32'h80010000);

      // Bubble: kill controls, keep IR/PC/RD1.
      idle();
      bb = 1;
      cycle();
      check("bb_out", 32'(Out), 32'h0);
      check("bb_wbdata", WbData, 32'h0);

      // Flush beats enable and suppresses the store.
      idle();
      CLR = 1; EN = 1; In = 1; MemWrite_in = 1; R1_in = 32'h30; R2_in = 32'h55;
      cycle();
      mem_op(32'h30, 32'h0, 0, 0, 0, 0);
      check("flush_nowrite", WbData, 32'h0);

      // JAL link wraps and outranks MemtoReg.
      idle();
      EN = 1; In = 1; JAL_in = 1; PC_in = 32'hFFFFFFFC; MemtoReg_in = 1; R1_in = 32'h10;
      RegWrite_in = 1; WbRegNum_in = 5'd31;
      cycle();
      check("jal_link", WbData, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
